io_supply_seq_ctrl: RTL and testbench
=====================================

Name: io_supply_seq_ctrl

Overview:
- Digital sequencer on the core side of the IO ring. It consumes the VDDIO-good indication from the IO supply pad's level detector and controls the release of pad isolation and retention.
- On supply loss it forces the IO ring into a safe, isolated state and flags a sticky fault.
- Sits between the IO power pads and the pad-control fan-out logic.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for vddio_ok_i; must be >= 2.
- DEBOUNCE_CYC, 64, consecutive cycles vddio_ok must stay high before isolation is released; must be >= 1.
- ISO_DLY_CYC, 8, cycles between isolation release and retention release; must be >= 1.
- CNT_W, 8, shared counter width; must hold max(DEBOUNCE_CYC, ISO_DLY_CYC) - 1.

Ports:
- clk_i  in  1  sequencer clock (always-on domain).
- rst_ni  in  1  asynchronous active-low reset.
- vddio_ok_i  in  1  asynchronous VDDIO-good from the supply pad detector.
- en_i  in  1  software request to power up the IO ring (level).
- clr_fault_i  in  1  single-cycle pulse that clears FAULT.
- io_iso_o  out  1  pad isolation; 1 = isolated.
- io_ret_o  out  1  pad retention; 1 = retained.
- pad_oe_en_o  out  1  global output-enable permit for pads.
- pwr_good_o  out  1  IO ring fully up.
- fault_o  out  1  sticky supply-loss fault.
- state_o  out  3  state encoding, for debug.

Behaviour:
- Reset: state = OFF, sync flops = 0, counter = 0. Outputs: io_iso_o=1, io_ret_o=1, pad_oe_en_o=0, pwr_good_o=0, fault_o=0.
- Synchroniser: ok_s is vddio_ok_i passed through SYNC_STAGES flops. This is the only consumer of vddio_ok_i.
- Output timing: all outputs are a Moore decode of the state register and change on the edge that changes state. No output is combinational from any input.
- State encoding for state_o: OFF=0, DEBOUNCE=1, ISO_REL=2, ACTIVE=3, FAULT=4.
- OFF
  - Outputs: iso=1, ret=1, oe=0, pg=0, fault=0.
  - Transition: en_i=1 and ok_s=1 -> DEBOUNCE, counter cleared.
- DEBOUNCE
  - Outputs: same as OFF.
  - Counting: counter increments each cycle while ok_s=1.
  - Exit to ISO_REL: when ok_s=1 and counter==DEBOUNCE_CYC-1; counter cleared on exit.
  - ok_s=0 or en_i=0 -> OFF, counter cleared. A glitch is not a fault.
- ISO_REL
  - Outputs: iso=0, ret=1, oe=0, pg=0.
  - Counting: counter increments each cycle.
  - Exit to ACTIVE: when counter==ISO_DLY_CYC-1; counter cleared on exit.
  - ok_s=0 -> FAULT.
  - en_i=0 -> OFF.
- ACTIVE
  - Outputs: iso=0, ret=0, oe=1, pg=1.
  - ok_s=0 -> FAULT.
  - en_i=0 -> OFF (orderly shutdown). iso and ret reassert on the same edge.
- FAULT
  - Outputs: iso=1, ret=1, oe=0, pg=0, fault=1.
  - Transition: clr_fault_i=1 -> OFF. This is independent of ok_s and en_i.
  - If the OFF entry conditions still hold, re-sequencing starts on the next cycle.
- Priority: fault (ok_s=0) beats en_i=0 whenever both happen in ISO_REL or ACTIVE. clr_fault_i is ignored outside FAULT.
- Power-up latency: vddio_ok_i rising to pwr_good_o rising is SYNC_STAGES+1+DEBOUNCE_CYC+ISO_DLY_CYC cycles, given en_i already high. Defaults give 75 cycles.
- Counter: counts up only and never wraps, because exit compares happen before overflow.
- Elaboration error: raised if either delay parameter exceeds 2^CNT_W or is 0.
- Reset mid-operation: rst_ni low asynchronously forces the reset values above, including fault_o=0.

Optional Feature:
- Macro: IO_SUPPLY_SEQ_GLITCH_CNT_EN.
- With the macro, adds output glitch_cnt_o [7:0].
  - Increments on every DEBOUNCE->OFF abort caused by ok_s=0.
  - Saturates at 255.
  - Cleared by reset and by clr_fault_i, whatever the state.
- Without the macro, the port and counter do not exist. FSM behaviour is identical in both builds.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYC=4, ISO_DLY_CYC=2 unless noted):
- Nominal power-up: en_i=1, vddio_ok_i rises at cycle 0.
  - io_iso_o falls at edge 7.
  - io_ret_o falls, pad_oe_en_o and pwr_good_o rise at edge 9.
  - state_o sequence: 0,1,2,3.
- Debounce glitch: vddio_ok_i high for 3 cycles, then low 1, then high.
  - Returns to OFF with fault_o=0.
  - Power-up restarts; pwr_good_o rises 9 cycles after the final rise.
  - With the macro, glitch_cnt_o=1.
- Supply loss in ACTIVE: drop vddio_ok_i.
  - 3 cycles later state=FAULT, io_iso_o=1, io_ret_o=1, pad_oe_en_o=0, fault_o=1.
  - State holds until clr_fault_i pulses, then state=0.
- Simultaneous: en_i=0 on the same cycle ok_s falls in ACTIVE -> state FAULT, not OFF.
- Orderly shutdown: en_i=0 in ACTIVE -> next edge state=OFF, iso=1, ret=1, fault_o=0.
- Async reset mid-ISO_REL: rst_ni pulse low between edges -> outputs return immediately to reset values, without waiting for a clock edge.

Source files
------------

// File: rtl/io_supply_seq_ctrl.sv
// IO supply sequencer: debounces a synchronised VDDIO-good, then releases pad isolation and retention in order.
// Optional macro IO_SUPPLY_SEQ_GLITCH_CNT_EN adds glitch_cnt_o, a saturating count of debounce aborts caused by supply loss.
module io_supply_seq_ctrl #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 64,
  parameter int ISO_DLY_CYC  = 8,
  parameter int CNT_W        = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       vddio_ok_i,
  input  logic       en_i,
  input  logic       clr_fault_i,
  output logic       io_iso_o,
  output logic       io_ret_o,
  output logic       pad_oe_en_o,
  output logic       pwr_good_o,
  output logic       fault_o,
  output logic [2:0] state_o
`ifdef IO_SUPPLY_SEQ_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt_o
`endif
);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_ISO_REL  = 3'd2,
    ST_ACTIVE   = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_DLY_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("io_supply_seq_ctrl: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYC < 1 || DEBOUNCE_CYC > (1 << CNT_W)) begin : g_bad_deb
    $error("io_supply_seq_ctrl: DEBOUNCE_CYC out of range for CNT_W");
  end
  if (ISO_DLY_CYC < 1 || ISO_DLY_CYC > (1 << CNT_W)) begin : g_bad_iso
    $error("io_supply_seq_ctrl: ISO_DLY_CYC out of range for CNT_W");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_ok_s;
  state_t                 r_state;
  state_t                 w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_glitch_abort;

  // vddio_ok_i is asynchronous; this chain is its only consumer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], vddio_ok_i};
    end
  end

  assign w_ok_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_glitch_abort = 1'b0;
    unique case (r_state)
      ST_OFF: begin
        if (en_i && w_ok_s) begin
          w_state_next = ST_DEBOUNCE;
          w_cnt_next   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (!w_ok_s || !en_i) begin
          w_state_next   = ST_OFF;
          w_cnt_next     = '0;
          w_glitch_abort = !w_ok_s;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next = ST_ISO_REL;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      // Supply loss outranks a simultaneous software shutdown request.
      ST_ISO_REL: begin
        if (!w_ok_s) begin
          w_state_next = ST_FAULT;
          w_cnt_next   = '0;
        end else if (!en_i) begin
          w_state_next = ST_OFF;
          w_cnt_next   = '0;
        end else if (r_cnt == ISO_LAST) begin
          w_state_next = ST_ACTIVE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      ST_ACTIVE: begin
        if (!w_ok_s) begin
          w_state_next = ST_FAULT;
        end else if (!en_i) begin
          w_state_next = ST_OFF;
        end
      end
      ST_FAULT: begin
        if (clr_fault_i) begin
          w_state_next = ST_OFF;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = ST_OFF;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Moore decode only: outputs never depend combinationally on an input.
  always_comb begin
    io_iso_o    = 1'b1;
    io_ret_o    = 1'b1;
    pad_oe_en_o = 1'b0;
    pwr_good_o  = 1'b0;
    fault_o     = 1'b0;
    case (r_state)
      ST_ISO_REL: begin
        io_iso_o = 1'b0;
      end
      ST_ACTIVE: begin
        io_iso_o    = 1'b0;
        io_ret_o    = 1'b0;
        pad_oe_en_o = 1'b1;
        pwr_good_o  = 1'b1;
      end
      ST_FAULT: begin
        fault_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign state_o = r_state;

`ifdef IO_SUPPLY_SEQ_GLITCH_CNT_EN
  logic [7:0] r_glitch_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_glitch_cnt <= 8'd0;
    end else if (clr_fault_i) begin
      r_glitch_cnt <= 8'd0;
    end else if (w_glitch_abort && (r_glitch_cnt != 8'hFF)) begin
      r_glitch_cnt <= r_glitch_cnt + 8'd1;
    end
  end

  assign glitch_cnt_o = r_glitch_cnt;
`else
  logic w_unused_abort;
  assign w_unused_abort = w_glitch_abort;
`endif

endmodule

// File: tb/tb_io_supply_seq_ctrl.sv
// Directed bench for io_supply_seq_ctrl with SYNC_STAGES=2, DEBOUNCE_CYC=4, ISO_DLY_CYC=2.
// Glitch counter checks are compiled in when IO_SUPPLY_SEQ_GLITCH_CNT_EN is defined.
module tb_io_supply_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       vddio_ok;
  logic       en;
  logic       clr_fault;
  logic       io_iso;
  logic       io_ret;
  logic       pad_oe_en;
  logic       pwr_good;
  logic       fault;
  logic [2:0] state;
`ifdef IO_SUPPLY_SEQ_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  io_supply_seq_ctrl #(
    .SYNC_STAGES (2),
    .DEBOUNCE_CYC(4),
    .ISO_DLY_CYC (2),
    .CNT_W       (4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .vddio_ok_i (vddio_ok),
    .en_i       (en),
    .clr_fault_i(clr_fault),
    .io_iso_o   (io_iso),
    .io_ret_o   (io_ret),
    .pad_oe_en_o(pad_oe_en),
    .pwr_good_o (pwr_good),
    .fault_o    (fault),
    .state_o    (state)
`ifdef IO_SUPPLY_SEQ_GLITCH_CNT_EN
    ,
    .glitch_cnt_o(glitch_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected order: iso, ret, oe, pg, fault, state
  task automatic check_all(input string tag, input logic e_iso, input logic e_ret,
                           input logic e_oe, input logic e_pg, input logic e_fault,
                           input logic [2:0] e_state);
    check({tag, ".iso"},   {7'd0, io_iso},    {7'd0, e_iso});
    check({tag, ".ret"},   {7'd0, io_ret},    {7'd0, e_ret});
    check({tag, ".oe"},    {7'd0, pad_oe_en}, {7'd0, e_oe});
    check({tag, ".pg"},    {7'd0, pwr_good},  {7'd0, e_pg});
    check({tag, ".fault"}, {7'd0, fault},     {7'd0, e_fault});
    check({tag, ".state"}, {5'd0, state},     {5'd0, e_state});
  endtask

  initial begin
    rst_n     = 1'b0;
    vddio_ok  = 1'b0;
    en        = 1'b0;
    clr_fault = 1'b0;
    #2;
    check_all("reset", 1, 1, 0, 0, 0, 3'd0);
`ifdef IO_SUPPLY_SEQ_GLITCH_CNT_EN
    check("reset.gcnt", glitch_cnt, 8'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    check_all("idle", 1, 1, 0, 0, 0, 3'd0);

    // Nominal power-up: supply and enable rise together at cycle 0
    en = 1'b1; vddio_ok = 1'b1;
    tick(2);
    check("nom.e2.state", {5'd0, state}, 8'd0);
    tick(1);
    check("nom.e3.state", {5'd0, state}, 8'd1);
    tick(3);
    check_all("nom.e6", 1, 1, 0, 0, 0, 3'd1);
    tick(1);
    check_all("nom.e7", 0, 1, 0, 0, 0, 3'd2);
    tick(1);
    check_all("nom.e8", 0, 1, 0, 0, 0, 3'd2);
    tick(1);
    check_all("nom.e9", 0, 0, 1, 1, 0, 3'd3);

    // Orderly shutdown
    en = 1'b0;
    tick(1);
    check_all("shutdown", 1, 1, 0, 0, 0, 3'd0);

    // Debounce glitch: high 3 cycles, low 1, then high
    vddio_ok = 1'b0;
    tick(3);
    en = 1'b1; vddio_ok = 1'b1;
    tick(3);
    check("gl.e3.state", {5'd0, state}, 8'd1);
    vddio_ok = 1'b0;
    tick(1);
    vddio_ok = 1'b1;
    tick(1);
    check("gl.e5.state", {5'd0, state}, 8'd1);
    tick(1);
    check_all("gl.e6", 1, 1, 0, 0, 0, 3'd0);
`ifdef IO_SUPPLY_SEQ_GLITCH_CNT_EN
    check("gl.gcnt", glitch_cnt, 8'd1);
`endif
    tick(1);
    check("gl.e7.state", {5'd0, state}, 8'd1);
    tick(5);
    check("gl.e12.pg", {7'd0, pwr_good}, 8'd0);
    tick(1);
    check_all("gl.e13", 0, 0, 1, 1, 0, 3'd3);

    // Supply loss in ACTIVE
    vddio_ok = 1'b0;
    tick(2);
    check_all("loss.e2", 0, 0, 1, 1, 0, 3'd3);
    tick(1);
    check_all("loss.e3", 1, 1, 0, 0, 1, 3'd4);
    tick(5);
    check_all("loss.hold", 1, 1, 0, 0, 1, 3'd4);
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    check_all("loss.clr", 1, 1, 0, 0, 0, 3'd0);
`ifdef IO_SUPPLY_SEQ_GLITCH_CNT_EN
    check("loss.gcnt", glitch_cnt, 8'd0);
`endif

    // Back up to ACTIVE, then clr_fault outside FAULT must be ignored
    vddio_ok = 1'b1;
    tick(9);
    check("re.e9.state", {5'd0, state}, 8'd3);
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    check("clr_ignored.state", {5'd0, state}, 8'd3);

    // Simultaneous supply loss and disable: fault wins
    vddio_ok = 1'b0;
    tick(2);
    en = 1'b0;
    tick(1);
    check_all("simul", 1, 1, 0, 0, 1, 3'd4);

    // Clear with entry conditions already true re-sequences next cycle
    vddio_ok = 1'b1; en = 1'b1;
    tick(2);
    check("resq.hold", {5'd0, state}, 8'd4);
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    check("resq.off", {5'd0, state}, 8'd0);
    tick(1);
    check("resq.deb", {5'd0, state}, 8'd1);
    tick(4);
    check_all("resq.iso", 0, 1, 0, 0, 0, 3'd2);

    // Async reset mid-ISO_REL, between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 1, 1, 0, 0, 0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("post_rst.state", {5'd0, state}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
